// File: rtl/ext_tran_master.sv
`default_nettype none
// ============================================================================
// Module   : ext_tran_master
// Purpose  : Converts a simple start/clear transaction request into a single
//            Wishbone classic read or write of a byte, halfword or word.
//            Misaligned or reserved-size requests finish immediately with an
//            error and issue no bus cycle. A wait counter bounds the wait for
//            a slave response.
// Ports    : clk_i, rst_i                       clock, sync active-high reset
//            ext_tran_addr_i/data_i/size_i      request address, data, size
//            ext_tran_start_i/write_i/clear_i   launch level, direction, ack
//            ext_tran_data_o/ready_o/error_o    read result and completion
//            wb_cyc_o/stb_o/we_o/adr_o/dat_o/sel_o  Wishbone master outputs
//            wb_dat_i/ack_i/err_i               Wishbone slave responses
// Revision : 1.0 - initial release
// ============================================================================
module ext_tran_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] ext_tran_addr_i,
  input  logic [31:0] ext_tran_data_i,
  input  logic [1:0]  ext_tran_size_i,
  input  logic        ext_tran_start_i,
  input  logic        ext_tran_write_i,
  input  logic        ext_tran_clear_i,
  output logic [31:0] ext_tran_data_o,
  output logic        ext_tran_ready_o,
  output logic        ext_tran_error_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam int               CNT_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_BUS  = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

  localparam logic [1:0] c_SZ_BYTE = 2'd0;
  localparam logic [1:0] c_SZ_HALF = 2'd1;
  localparam logic [1:0] c_SZ_WORD = 2'd2;
  localparam logic [1:0] c_SZ_RSVD = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             start_q;
  logic             arm_q;
  logic [31:0]      addr_q;
  logic [31:0]      data_q;
  logic [1:0]       size_q;
  logic             we_q;
  logic [CNT_W-1:0] wait_q;
  logic             err_q;
  logic [31:0]      rdata_q;

  logic             w_start_edge;
  logic             w_bad_req;
  logic             w_resp;
  logic             w_timeout;
  logic [31:0]      w_shift;
  logic [31:0]      w_lane;

  // arm_q keeps a start level that was already high when reset released from
  // looking like a fresh edge: start must be seen low once after reset.
  assign w_start_edge = ext_tran_start_i & ~start_q & arm_q;

  assign w_bad_req = (ext_tran_size_i == c_SZ_RSVD) ||
                     ((ext_tran_size_i == c_SZ_HALF) && ext_tran_addr_i[0]) ||
                     ((ext_tran_size_i == c_SZ_WORD) && (ext_tran_addr_i[1:0] != 2'b00));

  assign w_resp    = wb_ack_i | wb_err_i;
  assign w_timeout = (wait_q == c_WAIT_LAST);

  // Move the addressed lane down to bit 0; halfwords are aligned so the shift
  // is 0 or 16 for them.
  assign w_shift = wb_dat_i >> {addr_q[1:0], 3'b000};

  always_comb begin
    w_lane = wb_dat_i;
    case (size_q)
      c_SZ_BYTE: w_lane = {24'd0, w_shift[7:0]};
      c_SZ_HALF: w_lane = {16'd0, w_shift[15:0]};
      default:   w_lane = wb_dat_i;
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= c_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE: begin
        if (w_start_edge) begin
          state_d = w_bad_req ? c_ST_DONE : c_ST_BUS;
        end
      end
      c_ST_BUS: begin
        if (w_resp || w_timeout) begin
          state_d = c_ST_DONE;
        end
      end
      c_ST_DONE: begin
        if (ext_tran_clear_i) begin
          state_d = c_ST_IDLE;
        end
      end
      default: state_d = c_ST_IDLE;
    endcase
  end

  // Request latch, wait counter, error flag and read result
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      start_q <= 1'b0;
      arm_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      wait_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      start_q <= ext_tran_start_i;
      if (!ext_tran_start_i) begin
        arm_q <= 1'b1;
      end
      case (state_q)
        c_ST_IDLE: begin
          if (w_start_edge) begin
            addr_q <= ext_tran_addr_i;
            data_q <= ext_tran_data_i;
            size_q <= ext_tran_size_i;
            we_q   <= ext_tran_write_i;
            wait_q <= '0;
            err_q  <= w_bad_req;
          end
        end
        c_ST_BUS: begin
          // A response in the final wait cycle still counts as a response.
          if (w_resp) begin
            err_q <= wb_err_i;
            if (!wb_err_i && !we_q) begin
              rdata_q <= w_lane;
            end
          end else if (w_timeout) begin
            err_q <= 1'b1;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        c_ST_DONE: begin
          if (ext_tran_clear_i) begin
            err_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: bus signals are only driven while the cycle is open
  always_comb begin
    wb_cyc_o         = 1'b0;
    wb_stb_o         = 1'b0;
    wb_we_o          = 1'b0;
    wb_adr_o         = '0;
    wb_dat_o         = '0;
    wb_sel_o         = '0;
    ext_tran_ready_o = (state_q == c_ST_DONE);
    if (state_q == c_ST_BUS) begin
      wb_cyc_o = 1'b1;
      wb_stb_o = 1'b1;
      wb_we_o  = we_q;
      wb_adr_o = {addr_q[31:2], 2'b00};
      case (size_q)
        c_SZ_BYTE: begin
          wb_sel_o = 4'b0001 << addr_q[1:0];
          wb_dat_o = {4{data_q[7:0]}};
        end
        c_SZ_HALF: begin
          wb_sel_o = addr_q[1] ? 4'b1100 : 4'b0011;
          wb_dat_o = {2{data_q[15:0]}};
        end
        default: begin
          wb_sel_o = 4'b1111;
          wb_dat_o = data_q;
        end
      endcase
    end
  end

  assign ext_tran_error_o = err_q;
  assign ext_tran_data_o  = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ext_tran_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_ext_tran_master
// Purpose  : Self-checking bench for ext_tran_master. Directed vectors from a
//            table, hand-written multi-cycle sequences (timeout, reset during
//            a bus cycle, start coinciding with clear) and randomized
//            transactions checked against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ext_tran_master;

  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr_i, data_i;
  logic [1:0]  size_i;
  logic        start_i, write_i, clear_i;
  logic [31:0] data_o;
  logic        ready_o, error_o;
  logic        cyc_o, stb_o, we_o;
  logic [31:0] adr_o, wdat_o;
  logic [3:0]  sel_o;
  logic [31:0] wb_dat_i;
  logic        ack_i, err_i;

  always #5 clk = ~clk;

  ext_tran_master #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .ext_tran_addr_i  (addr_i),
    .ext_tran_data_i  (data_i),
    .ext_tran_size_i  (size_i),
    .ext_tran_start_i (start_i),
    .ext_tran_write_i (write_i),
    .ext_tran_clear_i (clear_i),
    .ext_tran_data_o  (data_o),
    .ext_tran_ready_o (ready_o),
    .ext_tran_error_o (error_o),
    .wb_cyc_o         (cyc_o),
    .wb_stb_o         (stb_o),
    .wb_we_o          (we_o),
    .wb_adr_o         (adr_o),
    .wb_dat_o         (wdat_o),
    .wb_sel_o         (sel_o),
    .wb_dat_i         (wb_dat_i),
    .wb_ack_i         (ack_i),
    .wb_err_i         (err_i)
  );

  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] model_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit m_bad(input logic [31:0] a, input logic [1:0] s);
    if (s == 2'd3) return 1'b1;
    return (a % (32'd1 << s)) != 0;
  endfunction

  function automatic logic [3:0] m_sel(input logic [31:0] a, input logic [1:0] s);
    int n = 1 << s;
    int m = ((1 << n) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdat(input logic [31:0] d, input logic [1:0] s);
    int n = 1 << s;
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = d[8*(b % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_rd(input logic [31:0] sd, input logic [31:0] a, input logic [1:0] s);
    int n = 1 << s;
    logic [63:0] mask = (64'd1 << (8 * n)) - 64'd1;
    logic [63:0] v = ({32'd0, sd} >> (8 * (a % 4))) & mask;
    return v[31:0];
  endfunction

  // rtype: 0 ack, 1 err, 2 ack+err, 3 no response
  function automatic int m_lat(input bit bad, input int rtype, input int delay);
    if (bad) return 1;
    if (rtype == 3) return TIMEOUT + 1;
    return 2 + delay;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] addr, data, sdat;
    logic [1:0]  size;
    bit          write;
    int          delay, rtype;
    logic [3:0]  e_sel;
    logic [31:0] e_adr, e_wdat, e_data;
    bit          e_err;
    int          e_lat;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] a, d, input logic [1:0] s, input bit w,
                              input int dl, rt, input logic [31:0] sd, input logic [3:0] es,
                              input logic [31:0] ea, ew, ed, input bit ee, input int el);
    vec_t v;
    v.addr = a; v.data = d; v.size = s; v.write = w; v.delay = dl; v.rtype = rt;
    v.sdat = sd; v.e_sel = es; v.e_adr = ea; v.e_wdat = ew; v.e_data = ed;
    v.e_err = ee; v.e_lat = el;
    return v;
  endfunction

  // One full transaction: launch, act as slave, check, clear, check no relaunch.
  task automatic do_txn(input string tag, input logic [31:0] a, d, input logic [1:0] s,
                        input bit w, input int delay, rtype, input logic [31:0] sd,
                        input logic [3:0] e_sel, input logic [31:0] e_adr, e_wdat, e_data,
                        input bit e_err, input int e_lat, input bit retoggle);
    int k = 0, stbn = 0;
    bit seen = 0, expired = 0, stb_bad = 0, stray = 0;
    start_i = 1'b0;
    @(negedge clk);
    addr_i = a; data_i = d; size_i = s; write_i = w; wb_dat_i = sd;
    start_i = 1'b1;
    forever begin
      @(negedge clk);
      k++;
      ack_i = 1'b0; err_i = 1'b0;
      if (retoggle && k == 10) start_i = 1'b0;
      if (retoggle && k == 11) start_i = 1'b1;
      if (ready_o) break;
      if (k > TIMEOUT + 20) begin expired = 1; break; end
      if (cyc_o) begin
        if (stb_o !== 1'b1) stb_bad = 1;
        if (!seen) begin
          seen = 1;
          chk({tag, ".adr"}, adr_o, e_adr);
          chk({tag, ".sel"}, {28'd0, sel_o}, {28'd0, e_sel});
          chk({tag, ".we"}, {31'd0, we_o}, {31'd0, w});
          if (w) chk({tag, ".wdat"}, wdat_o, e_wdat);
        end
        if (stbn == delay && rtype != 3) begin
          ack_i = (rtype != 1);
          err_i = (rtype != 0);
        end
        stbn++;
      end
    end
    chk({tag, ".expired"}, {31'd0, expired}, 32'd0);
    chk({tag, ".latency"}, k, e_lat);
    chk({tag, ".stb_cycles"}, stbn, e_lat - 1);
    chk({tag, ".stb_follows_cyc"}, {31'd0, stb_bad}, 32'd0);
    chk({tag, ".error"}, {31'd0, error_o}, {31'd0, e_err});
    chk({tag, ".data_o"}, data_o, e_data);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    chk({tag, ".clr_ready"}, {31'd0, ready_o}, 32'd0);
    chk({tag, ".clr_error"}, {31'd0, error_o}, 32'd0);
    chk({tag, ".clr_data"}, data_o, e_data);
    repeat (3) begin
      @(negedge clk);
      if (cyc_o || ready_o) stray = 1;
    end
    chk({tag, ".no_relaunch"}, {31'd0, stray}, 32'd0);
    start_i = 1'b0;
  endtask

  vec_t tbl[9];

  initial begin
    bit stray;
    rst = 1'b1; start_i = 0; clear_i = 0; write_i = 0; size_i = 0;
    addr_i = 0; data_i = 0; wb_dat_i = 0; ack_i = 0; err_i = 0;
    model_data = 32'd0;

    //             addr          data          sz w  dl rt sdat          sel      adr           wdat          data_o        err lat
    tbl[0] = mk(32'h100,      32'h0,        2, 0, 3, 0, 32'hDEADBEEF, 4'b1111, 32'h100, 32'h0,        32'hDEADBEEF, 0, 5);
    tbl[1] = mk(32'h203,      32'hA5,       0, 1, 1, 0, 32'h0,        4'b1000, 32'h200, 32'hA5A5A5A5, 32'hDEADBEEF, 0, 3);
    tbl[2] = mk(32'h102,      32'h0,        1, 0, 0, 0, 32'h1234ABCD, 4'b1100, 32'h100, 32'h0,        32'h00001234, 0, 2);
    tbl[3] = mk(32'h102,      32'h0,        2, 0, 0, 0, 32'h0,        4'b0000, 32'h0,   32'h0,        32'h00001234, 1, 1);
    tbl[4] = mk(32'h0,        32'h0,        3, 0, 0, 0, 32'h0,        4'b0000, 32'h0,   32'h0,        32'h00001234, 1, 1);
    tbl[5] = mk(32'h101,      32'h55,       1, 1, 0, 0, 32'h0,        4'b0000, 32'h0,   32'h0,        32'h00001234, 1, 1);
    tbl[6] = mk(32'h40,       32'hCAFEF00D, 2, 1, 2, 1, 32'h0,        4'b1111, 32'h40,  32'hCAFEF00D, 32'h00001234, 1, 4);
    tbl[7] = mk(32'h2,        32'h0,        1, 0, 0, 2, 32'hFFFF0000, 4'b1100, 32'h0,   32'h0,        32'h00001234, 1, 2);
    tbl[8] = mk(32'h1,        32'h0,        0, 0, 0, 0, 32'h00005A00, 4'b0010, 32'h0,   32'h0,        32'h0000005A, 0, 2);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.cyc",   {31'd0, cyc_o},   32'd0);
    chk("rst.stb",   {31'd0, stb_o},   32'd0);
    chk("rst.we",    {31'd0, we_o},    32'd0);
    chk("rst.sel",   {28'd0, sel_o},   32'd0);
    chk("rst.adr",   adr_o,            32'd0);
    chk("rst.wdat",  wdat_o,           32'd0);
    chk("rst.data",  data_o,           32'd0);
    chk("rst.ready", {31'd0, ready_o}, 32'd0);
    chk("rst.error", {31'd0, error_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 9; i++) begin
      do_txn($sformatf("vec%0d", i), tbl[i].addr, tbl[i].data, tbl[i].size, tbl[i].write,
             tbl[i].delay, tbl[i].rtype, tbl[i].sdat, tbl[i].e_sel, tbl[i].e_adr,
             tbl[i].e_wdat, tbl[i].e_data, tbl[i].e_err, tbl[i].e_lat, 1'b0);
      model_data = tbl[i].e_data;
    end

    // Start edge coinciding with clear in DONE must not launch
    start_i = 1'b0;
    @(negedge clk);
    addr_i = 32'h3; size_i = 2'd2; write_i = 1'b0; start_i = 1'b1;
    @(negedge clk);
    chk("coinc.ready", {31'd0, ready_o}, 32'd1);
    start_i = 1'b0;
    @(negedge clk);
    start_i = 1'b1; clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    chk("coinc.cleared", {31'd0, ready_o}, 32'd0);
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if (cyc_o || ready_o) stray = 1;
    end
    chk("coinc.no_launch", {31'd0, stray}, 32'd0);
    start_i = 1'b0;

    // Timeout with a second start edge during BUS
    do_txn("timeout", 32'h300, 32'h0, 2'd2, 1'b0, 0, 3, 32'h0, 4'b1111, 32'h300, 32'h0,
           model_data, 1'b1, TIMEOUT + 1, 1'b1);

    // Reset during BUS, start held high across reset
    start_i = 1'b0;
    @(negedge clk);
    addr_i = 32'h10; size_i = 2'd2; write_i = 1'b0; start_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst.cyc_before", {31'd0, cyc_o}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.cyc",   {31'd0, cyc_o},   32'd0);
    chk("midrst.stb",   {31'd0, stb_o},   32'd0);
    chk("midrst.ready", {31'd0, ready_o}, 32'd0);
    chk("midrst.data",  data_o,           32'd0);
    model_data = 32'd0;
    stray = 0;
    repeat (5) begin
      @(negedge clk);
      if (cyc_o || ready_o) stray = 1;
    end
    chk("midrst.held_start_no_launch", {31'd0, stray}, 32'd0);
    do_txn("after_rst", 32'h10, 32'h0, 2'd2, 1'b0, 0, 0, 32'h11223344, 4'b1111, 32'h10,
           32'h0, 32'h11223344, 1'b0, 2, 1'b0);
    model_data = 32'h11223344;

    // Randomized transactions against the model
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, d, sd, ed;
      logic [1:0]  s;
      bit          w, bad, ee;
      int          dl, rt, r;
      a  = $urandom; d = $urandom; sd = $urandom;
      s  = 2'($urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      dl = $urandom_range(0, 6);
      r  = $urandom_range(0, 9);
      rt = (r <= 6) ? 0 : (r == 7) ? 1 : 2;
      bad = m_bad(a, s);
      ee  = bad || (rt != 0);
      ed  = (!bad && rt == 0 && !w) ? m_rd(sd, a, s) : model_data;
      do_txn($sformatf("rnd%0d", i), a, d, s, w, dl, rt, sd, m_sel(a, s), {a[31:2], 2'b00},
             m_wdat(d, s), ed, ee, m_lat(bad, rt, dl), 1'b0);
      model_data = ed;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ext_tran_master.md
EXT_TRAN_MASTER -- requirements
Module: ext_tran_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum cycles to wait for wb_ack_i before aborting.
REQ-002 clk_i  input  1  single clock; all logic on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 ext_tran_addr_i  input  32  transaction byte address.
REQ-005 ext_tran_data_i  input  32  write data, right-justified.
REQ-006 ext_tran_size_i  input  2  0=byte, 1=halfword, 2=word, 3=reserved.
REQ-007 ext_tran_start_i  input  1  level request; a transaction launches on its 0->1 transition.
REQ-008 ext_tran_write_i  input  1  1=write, 0=read; sampled at launch.
REQ-009 ext_tran_clear_i  input  1  acknowledges completion; returns block to idle.
REQ-010 ext_tran_data_o  output  32  read result, right-justified, zero-extended.
REQ-011 ext_tran_ready_o  output  1  transaction complete, result valid.
REQ-012 ext_tran_error_o  output  1  completed transaction failed (err, timeout, misalign, reserved size).
REQ-013 wb_cyc_o, wb_stb_o, wb_we_o  output  1 each  Wishbone master cycle/strobe/write-enable.
REQ-014 wb_adr_o  output  32  word-aligned address (bits [1:0] forced to 0).
REQ-015 wb_dat_o  output  32  write data, replicated to selected byte lanes.
REQ-016 wb_sel_o  output  4  byte-lane select.
REQ-017 wb_dat_i  input  32; wb_ack_i, wb_err_i  input  1 each  slave responses.

Function
REQ-018 States SHALL be IDLE, BUS, DONE.
REQ-019 A start rising edge SHALL be detected with a registered copy of ext_tran_start_i; edges in BUS or DONE are ignored and do not queue.
REQ-020 In IDLE, on a start edge, addr/data/size/write SHALL be latched; on reserved size or misalignment (half: addr[0]!=0; word: addr[1:0]!=0) go directly to DONE with error=1 and no bus cycle; otherwise go to BUS.
REQ-021 Bus cycle SHALL begin the cycle after launch: cyc=stb=1, we=latched write, adr={addr[31:2],2'b00}.
REQ-022 wb_sel_o: byte 4'b0001<<addr[1:0]; half addr[1]?4'b1100:4'b0011; word 4'b1111.
REQ-023 wb_dat_o: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
REQ-024 In BUS, cyc/stb SHALL stay high until wb_ack_i or wb_err_i is sampled high, then drop the next cycle; transition to DONE.
REQ-025 On ack for a read, ext_tran_data_o SHALL capture the selected lane shifted to bit 0 and zero-extended; writes leave ext_tran_data_o unchanged.
REQ-026 wb_err_i SHALL set error=1; if ack and err are both high, err wins, data not captured.
REQ-027 A wait counter SHALL clear at bus-cycle start, increment each BUS cycle; at TIMEOUT_CYCLES without response, drop cyc/stb, error=1, go to DONE.
REQ-028 ext_tran_ready_o SHALL be 1 exactly in DONE; error valid while ready=1.
REQ-029 In DONE, ext_tran_clear_i=1 SHALL return to IDLE next cycle, clearing ready and error; ext_tran_data_o retained.
REQ-030 ext_tran_clear_i in IDLE or BUS SHALL be ignored; an in-flight cycle is never aborted by clear.
REQ-031 Start edge coinciding with clear in DONE SHALL NOT launch; a new edge is required after IDLE.
REQ-032 Launch-to-ready latency SHALL be 2 + N cycles, N = cycles with stb high before response; misaligned/reserved: ready 1 cycle after launch edge sample.

Reset
REQ-033 While rst_i=1: state IDLE; cyc, stb, we, sel, adr, wb_dat_o, ext_tran_data_o, ready, error, wait counter, start history all 0.
REQ-034 rst_i during BUS SHALL drop cyc/stb the next cycle with no completion reported.
REQ-035 Start held high through reset release SHALL NOT launch (history reset to 0 counts as edge only if start was low after reset for one cycle).

Verification
REQ-036 Word read addr 0x100, slave acks after 3 cycles with 0xDEADBEEF -> sel=1111, data_o=0xDEADBEEF, ready=1 at launch+5, error=0.
REQ-037 Byte write addr 0x203 data 0xA5 -> sel=1000, wb_dat_o=0xA5A5A5A5, adr=0x200, we=1; ready after ack, data_o unchanged.
REQ-038 Halfword read addr 0x102, slave returns 0x1234ABCD -> data_o=0x00001234.
REQ-039 Word read addr 0x102 -> no cyc asserted, ready=1 error=1; clear -> ready=0 error=0 next cycle.
REQ-040 No ack with TIMEOUT_CYCLES=255 -> stb drops after 255 BUS cycles, ready=1 error=1; second start edge during BUS ignored.
REQ-041 rst_i asserted mid-BUS -> cyc=stb=0 next cycle, ready=0; start held high across reset -> no launch until toggled.
